atpg_resp_checker: RTL

ATPG_RESP_CHECKER -- requirements
Module: atpg_resp_checker

---
 rtl/atpg_resp_checker_if.sv | 48 ++++
 rtl/atpg_resp_checker.sv | 118 +++++++++++
 2 files changed

// File: rtl/atpg_resp_checker_if.sv
// Response-checker bus: expected-vector load port, run control, DUT response
// handshake and result outputs. The signature signal exists only when the
// design is built with ATPG_MISR_EN defined.
interface atpg_resp_checker_if #(
  parameter int RESP_W = 108,
  parameter int IDX_W  = 4
);
  logic              exp_we;
  logic [IDX_W-1:0]  exp_addr;
  logic [RESP_W-1:0] exp_wdata;
  logic              start;
  logic              resp_valid;
  logic [RESP_W-1:0] resp_data;
  logic              resp_ready;
  logic              busy;
  logic              done;
  logic              pass;
  logic [IDX_W:0]    fail_count;
  logic [IDX_W-1:0]  first_fail_idx;
  logic              first_fail_vld;
`ifdef ATPG_MISR_EN
  logic [RESP_W-1:0] signature;

  modport master (
    output exp_we, exp_addr, exp_wdata, start, resp_valid, resp_data,
    input  resp_ready, busy, done, pass, fail_count, first_fail_idx,
           first_fail_vld, signature
  );

  modport slave (
    input  exp_we, exp_addr, exp_wdata, start, resp_valid, resp_data,
    output resp_ready, busy, done, pass, fail_count, first_fail_idx,
           first_fail_vld, signature
  );
`else
  modport master (
    output exp_we, exp_addr, exp_wdata, start, resp_valid, resp_data,
    input  resp_ready, busy, done, pass, fail_count, first_fail_idx,
           first_fail_vld
  );

  modport slave (
    input  exp_we, exp_addr, exp_wdata, start, resp_valid, resp_data,
    output resp_ready, busy, done, pass, fail_count, first_fail_idx,
           first_fail_vld
  );
`endif
endinterface

// File: rtl/atpg_resp_checker.sv
// ATPG response checker: holds DEPTH expected vectors, compares each accepted
// DUT response against the expected vector at the running index and reports
// mismatch count, first failing index and pass/done.
// Optional macro ATPG_MISR_EN adds a MISR signature over accepted responses.
//
// state | meaning
// IDLE  | waiting for start, expected memory writable
// RUN   | accepting responses, idx walks 0..DEPTH-1
// DONE  | results valid and held, waiting for the next start
module atpg_resp_checker #(
  parameter int RESP_W = 108,
  parameter int DEPTH  = 10,
  parameter int IDX_W  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  atpg_resp_checker_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W:0]    fail_count;
  logic [IDX_W-1:0]  first_fail_idx;
  logic              first_fail_vld;
  logic [RESP_W-1:0] exp_mem [DEPTH];

  logic accept;
  logic start_ok;
  logic last;
  logic mismatch;
  logic wr_ok;

  assign accept   = bus.resp_valid && (state == RUN);
  assign start_ok = bus.start && (state != RUN);
  assign last     = (idx == IDX_W'(DEPTH - 1));
  assign mismatch = (bus.resp_data != exp_mem[idx]);
  // Out-of-range addresses are dropped rather than aliased onto a live entry.
  assign wr_ok    = bus.exp_we && (state != RUN) &&
                    ({1'b0, bus.exp_addr} < (IDX_W + 1)'(DEPTH));

  assign bus.resp_ready     = (state == RUN);
  assign bus.busy           = (state == RUN);
  assign bus.done           = (state == DONE);
  assign bus.pass           = (state == DONE) && (fail_count == '0);
  assign bus.fail_count     = fail_count;
  assign bus.first_fail_idx = first_fail_idx;
  assign bus.first_fail_vld = first_fail_vld;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (accept && last) state_next = DONE;
      DONE:    if (bus.start) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  // Run index and result accumulation; results land the cycle after accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx            <= '0;
      fail_count     <= '0;
      first_fail_idx <= '0;
      first_fail_vld <= 1'b0;
    end else if (start_ok) begin
      idx            <= '0;
      fail_count     <= '0;
      first_fail_idx <= '0;
      first_fail_vld <= 1'b0;
    end else if (accept) begin
      idx <= idx + 1'b1;
      if (mismatch) begin
        fail_count <= fail_count + 1'b1;
        if (!first_fail_vld) begin
          first_fail_idx <= idx;
          first_fail_vld <= 1'b1;
        end
      end
    end
  end

  // Expected-vector memory; intentionally not reset and not cleared by start.
  always_ff @(posedge clk) begin
    if (wr_ok) exp_mem[bus.exp_addr] <= bus.exp_wdata;
  end

`ifdef ATPG_MISR_EN
  logic [RESP_W-1:0] signature;
  logic              fb;

  assign fb            = signature[RESP_W-1] ^ signature[RESP_W-3] ^
                         signature[RESP_W-5] ^ signature[0];
  assign bus.signature = signature;

  // MISR over accepted responses; only moves in RUN so it holds in DONE.
  always_ff @(posedge clk) begin
    if (!rst_n)        signature <= '0;
    else if (start_ok) signature <= '0;
    else if (accept)   signature <= {signature[RESP_W-2:0], fb} ^ bus.resp_data;
  end
`endif

endmodule
